// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
//
// UART transmitter with a small holding FIFO. Words pushed on the write side
// are serialised as: start bit (0), DATA_BITS data bits LSB first, an optional
// parity bit, then one or two stop bits (1). Bit timing comes entirely from the
// external baud_tick strobe. The frame format (parity enable, parity sense,
// stop-bit count) is captured when a word is popped, so it is constant for the
// whole frame.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   FIFO_DEPTH  holding FIFO entries (power of 2, >= 2)
//
// Ports
//   clk               single clock, rising edge
//   reset             synchronous active-high reset
//   baud_tick         one-cycle pulse at each bit-period boundary
//   tx_en             permission to start new frames
//   wr_data           word to transmit
//   wr_valid          push request
//   wr_ready          FIFO not full
//   parity_en         append a parity bit
//   parity_odd        1 = odd parity, 0 = even
//   two_stop          1 = two stop bits, 0 = one
//   tx_out            serial line (registered, idle high)
//   busy              a frame is in progress
//   fifo_count        current FIFO occupancy
//   data_transmitted  one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module uart_tx_engine #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             baud_tick,
    input  logic                             tx_en,
    input  logic [DATA_BITS-1:0]             wr_data,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic                             parity_en,
    input  logic                             parity_odd,
    input  logic                             two_stop,
    output logic                             tx_out,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             data_transmitted
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // -------------------------------------------------------------------------
    // Holding FIFO
    // -------------------------------------------------------------------------
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head_word;

    // A full FIFO refuses the push even when a pop happens in the same cycle,
    // because wr_ready is derived from the registered count only.
    assign wr_ready = (count_reg != CNT_FULL);
    assign push     = wr_valid && wr_ready;

    // The head word is read asynchronously so it can be loaded into the shift
    // register on the very tick that pops it.
    assign head_word = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Transmit state machine
    // -------------------------------------------------------------------------
    state_t               state_reg,       state_next;
    logic [DATA_BITS-1:0] shift_reg,       shift_next;
    logic [IDX_W-1:0]     bit_idx_reg,     bit_idx_next;
    logic                 par_en_reg,      par_en_next;
    logic                 parity_bit_reg,  parity_bit_next;
    logic                 two_stop_reg,    two_stop_next;
    logic                 stop_second_reg, stop_second_next;
    logic                 tx_out_reg,      tx_out_next;
    logic                 done_reg,        done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            shift_reg       <= '0;
            bit_idx_reg     <= '0;
            par_en_reg      <= 1'b0;
            parity_bit_reg  <= 1'b0;
            two_stop_reg    <= 1'b0;
            stop_second_reg <= 1'b0;
            tx_out_reg      <= 1'b1;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            bit_idx_reg     <= bit_idx_next;
            par_en_reg      <= par_en_next;
            parity_bit_reg  <= parity_bit_next;
            two_stop_reg    <= two_stop_next;
            stop_second_reg <= stop_second_next;
            tx_out_reg      <= tx_out_next;
            done_reg        <= done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        bit_idx_next     = bit_idx_reg;
        par_en_next      = par_en_reg;
        parity_bit_next  = parity_bit_reg;
        two_stop_next    = two_stop_reg;
        stop_second_next = stop_second_reg;
        done_next        = 1'b0;
        pop              = 1'b0;
        tx_out_next      = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                if (baud_tick && tx_en && (count_reg != '0)) begin
                    pop        = 1'b1;
                    shift_next = head_word;
                    // Parity is fixed at pop time from the word itself, so the
                    // shifting data never has to be re-examined.
                    par_en_next     = parity_en;
                    parity_bit_next = (^head_word) ^ parity_odd;
                    two_stop_next   = two_stop;
                    state_next      = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    bit_idx_next = '0;
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift_next       = shift_reg >> 1;
                    bit_idx_next     = bit_idx_reg + IDX_W'(1);
                    stop_second_next = 1'b0;
                    if (bit_idx_reg == IDX_LAST) begin
                        state_next = par_en_reg ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    stop_second_next = 1'b0;
                    state_next       = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (two_stop_reg && !stop_second_reg) begin
                        stop_second_next = 1'b1;
                    end else begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The line level is computed from the upcoming state and registered,
        // so tx_out is a clean flop output aligned with state_reg.
        case (state_next)
            ST_START:  tx_out_next = 1'b0;
            ST_DATA:   tx_out_next = shift_next[0];
            ST_PARITY: tx_out_next = parity_bit_next;
            default:   tx_out_next = 1'b1;
        endcase
    end

    assign tx_out           = tx_out_reg;
    assign busy             = (state_reg != ST_IDLE);
    assign fifo_count       = count_reg;
    assign data_transmitted = done_reg;

endmodule

// File: tb/tb_uart_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_engine
//
// Directed bench for uart_tx_engine (DATA_BITS=8, FIFO_DEPTH=4). baud_tick is
// pulsed by the bench one bit at a time; the line is sampled just after each
// tick edge. Frame samples are packed with sample 0 (start bit) in bit 0.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       tx_en;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       parity_en;
    logic       parity_odd;
    logic       two_stop;
    logic       tx_out;
    logic       busy;
    logic [2:0] fifo_count;
    logic       data_transmitted;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int done_cnt  = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .baud_tick        (baud_tick),
        .tx_en            (tx_en),
        .wr_data          (wr_data),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .parity_en        (parity_en),
        .parity_odd       (parity_odd),
        .two_stop         (two_stop),
        .tx_out           (tx_out),
        .busy             (busy),
        .fifo_count       (fifo_count),
        .data_transmitted (data_transmitted)
    );

    // Count every cycle the completion strobe is high.
    always @(posedge clk) begin
        if (data_transmitted === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    // One baud tick followed by one quiet cycle; any push set up by the caller
    // is limited to the tick cycle.
    task automatic do_tick(output logic line, output logic bsy);
        baud_tick = 1'b1;
        @(posedge clk);
        #1;
        baud_tick = 1'b0;
        wr_valid  = 1'b0;
        line      = tx_out;
        bsy       = busy;
        @(posedge clk);
        #1;
    endtask

    // Runs n sampled ticks plus the closing tick that returns to IDLE, and
    // checks line pattern, busy throughout, one completion pulse, idle after.
    task automatic send_frame(input string tag, input int n, input logic [15:0] exp_bits,
                              input logic push_first, input logic [7:0] push_data,
                              input int chg_at, input logic [2:0] chg_cfg,
                              output logic [2:0] cnt_first);
        logic        line, bsy;
        logic [15:0] bits, busy_bits, mask;
        int          done_before;
        bits        = '0;
        busy_bits   = '0;
        cnt_first   = '0;
        done_before = done_cnt;
        mask        = 16'((32'd1 << n) - 1);
        for (int i = 0; i < n; i++) begin
            if (i == 0 && push_first) begin
                wr_valid = 1'b1;
                wr_data  = push_data;
            end
            if (i == chg_at) {parity_en, parity_odd, two_stop} = chg_cfg;
            do_tick(line, bsy);
            bits[i]      = line;
            busy_bits[i] = bsy;
            if (i == 0) cnt_first = fifo_count;
        end
        do_tick(line, bsy);
        check_val($sformatf("%s_bits", tag), 32'(bits), 32'(exp_bits));
        check_val($sformatf("%s_busy", tag), 32'(busy_bits), 32'(mask));
        check_val($sformatf("%s_done", tag), done_cnt - done_before, 1);
        check_val($sformatf("%s_idle", tag), {30'd0, busy, tx_out}, 32'h1);
    endtask

    logic [2:0] cnt1;
    logic       line, bsy;
    int         done_mark;

    initial begin
        reset      = 1'b1;
        baud_tick  = 1'b0;
        tx_en      = 1'b0;
        wr_data    = '0;
        wr_valid   = 1'b0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;

        // ---------------- reset state ----------------
        do_reset();
        check_val("rst_tx_out", tx_out, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", data_transmitted, 0);
        check_val("rst_count", fifo_count, 0);
        check_val("rst_ready", wr_ready, 1);

        // ---------------- 0x55, no parity, one stop ----------------
        tx_en = 1'b1;
        push_word(8'h55);
        check_val("p55_count", fifo_count, 1);
        send_frame("f55", 10, 16'h02AA, 1'b0, 8'h00, -1, 3'b000, cnt1);

        // ---------------- 0xA5 with parity variants ----------------
        parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b0;
        push_word(8'hA5);
        send_frame("fa5_even", 11, 16'h054A, 1'b0, 8'h00, -1, 3'b000, cnt1);
        parity_odd = 1'b1;
        push_word(8'hA5);
        send_frame("fa5_odd", 11, 16'h074A, 1'b0, 8'h00, -1, 3'b000, cnt1);
        parity_odd = 1'b0; two_stop = 1'b1;
        push_word(8'hA5);
        send_frame("fa5_2stop", 12, 16'h0D4A, 1'b0, 8'h00, -1, 3'b000, cnt1);

        // ---------------- FIFO fill with tx_en=0, overflow lost ----------------
        do_reset();
        tx_en = 1'b0; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        check_val("full_count", fifo_count, 4);
        check_val("full_ready", wr_ready, 0);
        push_word(8'h55);
        check_val("overflow_count", fifo_count, 4);
        do_tick(line, bsy);
        check_val("txen0_busy", bsy, 0);
        check_val("txen0_count", fifo_count, 4);
        tx_en = 1'b1;
        send_frame("q11", 10, 16'h0222, 1'b0, 8'h00, -1, 3'b000, cnt1);
        send_frame("q22", 10, 16'h0244, 1'b0, 8'h00, -1, 3'b000, cnt1);
        send_frame("q33", 10, 16'h0266, 1'b0, 8'h00, -1, 3'b000, cnt1);
        send_frame("q44", 10, 16'h0288, 1'b0, 8'h00, -1, 3'b000, cnt1);
        check_val("drained_count", fifo_count, 0);
        do_tick(line, bsy);
        check_val("drained_busy", bsy, 0);
        check_val("drained_line", line, 1);

        // ---------------- simultaneous push and pop ----------------
        do_reset();
        tx_en = 1'b0;
        push_word(8'h01);
        push_word(8'h02);
        tx_en = 1'b1;
        send_frame("sp01", 10, 16'h0202, 1'b1, 8'h03, -1, 3'b000, cnt1);
        check_val("pushpop_cnt2", cnt1, 2);
        tx_en = 1'b0;
        push_word(8'h04);
        push_word(8'h05);
        check_val("refill_count", fifo_count, 4);
        tx_en = 1'b1;
        send_frame("sp02", 10, 16'h0204, 1'b1, 8'h99, -1, 3'b000, cnt1);
        check_val("pushpop_full", cnt1, 3);
        send_frame("sp03", 10, 16'h0206, 1'b0, 8'h00, -1, 3'b000, cnt1);
        send_frame("sp04", 10, 16'h0208, 1'b0, 8'h00, -1, 3'b000, cnt1);
        send_frame("sp05", 10, 16'h020A, 1'b0, 8'h00, -1, 3'b000, cnt1);
        check_val("sp_empty", fifo_count, 0);

        // ---------------- config change during DATA ----------------
        do_reset();
        tx_en = 1'b0; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        push_word(8'hA5);
        push_word(8'hA5);
        tx_en = 1'b1;
        send_frame("cfg_cur", 10, 16'h034A, 1'b0, 8'h00, 4, 3'b101, cnt1);
        send_frame("cfg_next", 12, 16'h0D4A, 1'b0, 8'h00, -1, 3'b000, cnt1);

        // ---------------- reset during data bit 3 ----------------
        do_reset();
        tx_en = 1'b0; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        push_word(8'h00);
        push_word(8'h12);
        push_word(8'h34);
        tx_en = 1'b1;
        for (int i = 0; i < 5; i++) do_tick(line, bsy);
        check_val("bit3_line", line, 0);
        check_val("bit3_busy", bsy, 1);
        check_val("bit3_count", fifo_count, 2);
        done_mark = done_cnt;
        reset    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        @(posedge clk);
        #1;
        check_val("abort_tx_out", tx_out, 1);
        check_val("abort_busy", busy, 0);
        check_val("abort_count", fifo_count, 0);
        check_val("abort_ready", wr_ready, 1);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        wr_valid = 1'b0;
        check_val("rst_push_dropped", fifo_count, 0);
        for (int i = 0; i < 3; i++) do_tick(line, bsy);
        check_val("post_abort_idle", {30'd0, bsy, line}, 32'h1);
        check_val("abort_no_done", done_cnt - done_mark, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
